// File: rtl/pipelined_ripple_adder.sv
// Pipelined ripple-carry add/subtract: WIDTH-bit chain cut into STAGES
// equal ripple segments with a register after each, valid/ready on both ends.
module pipelined_ripple_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);
    localparam int SEG = WIDTH / STAGES;

    // Only a held result at the tail can stall; bubbles never block the pipe.
    logic en;
    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;

    for (genvar k = 1; k <= STAGES; k++) begin : g_stg
        localparam int LO = (k - 1) * SEG;
        localparam int HI = k * SEG;

        logic                v_in;
        logic                ci;
        logic [WIDTH-LO-1:0] op_a;
        logic [WIDTH-LO-1:0] op_b;
        logic [SEG-1:0]      seg_s;
        logic                seg_co;
        logic [HI-1:0]       s_nxt;
        logic                vld;
        logic [HI-1:0]       s_q;
        logic                c_q;

        // Operands shrink as they travel: each register keeps only the bits
        // not yet summed, so segment k always works on the low SEG bits.
        if (k == 1) begin : g_src
            assign v_in  = in_valid;
            assign op_a  = a;
            assign op_b  = b ^ {WIDTH{sub}};
            assign ci    = sub | cin;
            assign s_nxt = seg_s;
        end else begin : g_src
            assign v_in  = g_stg[k-1].vld;
            assign op_a  = g_stg[k-1].g_op.a_q;
            assign op_b  = g_stg[k-1].g_op.b_q;
            assign ci    = g_stg[k-1].c_q;
            assign s_nxt = {seg_s, g_stg[k-1].s_q};
        end

        prra_seg #(.SEG(SEG)) u_seg (
            .a  (op_a[SEG-1:0]),
            .b  (op_b[SEG-1:0]),
            .ci (ci),
            .s  (seg_s),
            .co (seg_co)
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld <= 1'b0;
                s_q <= '0;
                c_q <= 1'b0;
            end else if (en) begin
                vld <= v_in;
                s_q <= s_nxt;
                c_q <= seg_co;
            end
        end

        if (k < STAGES) begin : g_op
            logic [WIDTH-HI-1:0] a_q;
            logic [WIDTH-HI-1:0] b_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en) begin
                    a_q <= op_a[WIDTH-LO-1:SEG];
                    b_q <= op_b[WIDTH-LO-1:SEG];
                end
            end
        end else begin : g_msb
            // Carry into the MSB recovered from the MSB sum bit: c = s ^ a ^ b.
            logic cm_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    cm_q <= 1'b0;
                else if (en)
                    cm_q <= seg_s[SEG-1] ^ op_a[SEG-1] ^ op_b[SEG-1];
            end
        end
    end

    assign out_valid = g_stg[STAGES].vld;
    assign s         = g_stg[STAGES].s_q;
    assign cout      = g_stg[STAGES].c_q;
    assign ovf       = g_stg[STAGES].g_msb.cm_q ^ g_stg[STAGES].c_q;

endmodule

// One carry-chain segment: SEG full adders rippling bit by bit.
module prra_seg #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co
);
    logic [SEG:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < SEG; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign co = c[SEG];

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Bench for pipelined_ripple_adder: directed vectors, backpressure/reset
// sequences, random streaming and an 8-bit STAGES sweep vs arithmetic model.
module tb_pipelined_ripple_adder;
    localparam int W = 16;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [W-1:0] a, b, s;

    always #5 clk = ~clk;

    pipelined_ripple_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .s(s), .cout(cout), .ovf(ovf)
    );

    // 8-bit sweep instances: STAGES = 1, 2, 8, never backpressured.
    logic       v8, c8, sb8;
    logic [7:0] a8, b8;
    logic       rdy8 [3];
    logic       ov8  [3];
    logic       co8  [3];
    logic       of8  [3];
    logic [7:0] s8   [3];

    for (genvar gi = 0; gi < 3; gi++) begin : g_sw
        pipelined_ripple_adder #(.WIDTH(8), .STAGES(gi == 0 ? 1 : (gi == 1 ? 2 : 8))) u_sw (
            .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8[gi]),
            .a(a8), .b(b8), .cin(c8), .sub(sb8), .out_valid(ov8[gi]),
            .out_ready(1'b1), .s(s8[gi]), .cout(co8[gi]), .ovf(of8[gi])
        );
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: plain modular sum for s/cout, true signed result for ovf.
    // Returns {ovf, cout, s[15:0]}.
    function automatic logic [17:0] model(input int w, input logic [15:0] x, input logic [15:0] y,
                                          input logic ci, input logic sb);
        longint mask, half, ux, uy, ny, full, sx, sy, tru;
        logic [15:0] yn;
        logic        co, ov;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        yn   = ~y;
        ux   = longint'(x) & mask;
        ny   = longint'(y) & mask;
        uy   = sb ? (longint'(yn) & mask) : ny;
        full = ux + uy + (sb ? longint'(1) : longint'(ci));
        sx   = (ux >= half) ? ux - 2 * half : ux;
        sy   = (ny >= half) ? ny - 2 * half : ny;
        tru  = sb ? sx - sy : sx + sy + longint'(ci);
        ov   = (tru >= half) || (tru < -half);
        co   = ((full >> w) & 1) != 0;
        return {ov, co, 16'(full & mask)};
    endfunction

    typedef struct {
        logic [15:0] a, b;
        logic        cin, sub;
        logic [15:0] es;
        logic        ec, eo;
    } vec_t;

    vec_t tbl [8];

    task automatic run_one(input vec_t v, input string nm);
        int lat;
        a = v.a; b = v.b; cin = v.cin; sub = v.sub; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check({nm, "_in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({nm, "_latency"}, lat, S);
        check({nm, "_s"}, s, v.es);
        check({nm, "_cout"}, cout, v.ec);
        check({nm, "_ovf"}, ovf, v.eo);
        @(posedge clk); #1;
        check({nm, "_pulse"}, out_valid, 0);
    endtask

    // Streams n random sets through a scoreboard. rnd=0: in_valid always
    // offered, out_ready low in cycles 5..8; rnd=1: both sides random.
    task automatic run_stream(input int n, input bit rnd, input string nm);
        logic [17:0] expq[$];
        int sent, got, cyc, stalls;
        bit acc;
        sent = 0; got = 0; cyc = 0; stalls = 0;
        in_valid = 1'b0;
        while (got < n && cyc < 2000) begin
            cyc++;
            if (!in_valid && sent < n && (!rnd || ($urandom % 4 != 0))) begin
                a = 16'($urandom); b = 16'($urandom);
                cin = 1'($urandom); sub = 1'($urandom);
                in_valid = 1'b1;
            end
            out_ready = rnd ? ($urandom % 3 != 0) : !(cyc >= 5 && cyc <= 8);
            #1;
            check({nm, "_in_ready"}, in_ready, !(out_valid && !out_ready));
            if (out_valid && !out_ready) stalls++;
            if (out_valid) begin
                if (expq.size() == 0) begin
                    check({nm, "_spurious"}, 1, 0);
                end else begin
                    check({nm, "_s"}, s, expq[0][15:0]);
                    check({nm, "_cout"}, cout, expq[0][16]);
                    check({nm, "_ovf"}, ovf, expq[0][17]);
                    if (out_ready) begin
                        void'(expq.pop_front());
                        got++;
                    end
                end
            end
            acc = in_valid && in_ready;
            if (acc) begin
                expq.push_back(model(16, a, b, cin, sub));
                sent++;
            end
            @(posedge clk); #1;
            if (acc) in_valid = 1'b0;
        end
        check({nm, "_delivered"}, got, n);
        check({nm, "_leftover"}, expq.size(), 0);
        if (!rnd) check({nm, "_stall_cycles"}, stalls, 4);
        out_ready = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int stale, st, src;
        logic ev;
        logic [17:0] r;
        logic       hv  [256];
        logic       hc  [256];
        logic       hs  [256];
        logic [7:0] ha  [256];
        logic [7:0] hb  [256];

        tbl[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tbl[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        tbl[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        tbl[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[7] = '{16'h0010, 16'h0001, 1'b0, 1'b1, 16'h000F, 1'b1, 1'b0};

        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        v8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0; sb8 = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_s", s, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) run_one(tbl[i], $sformatf("vec%0d", i));

        run_stream(6, 1'b0, "bp");

        // Reset while a finished result is held by backpressure.
        a = 16'hFFFF; b = 16'h8000; cin = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("hold_valid", out_valid, 1);
        check("hold_s", s, 16'h7FFF);
        check("hold_cout", cout, 1);
        check("hold_ovf", ovf, 1);
        check("hold_in_ready", in_ready, 0);
        rst_n = 1'b0;
        #1;
        check("stallrst_valid", out_valid, 0);
        check("stallrst_s", s, 0);
        check("stallrst_cout", cout, 0);
        check("stallrst_ovf", ovf, 0);
        @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b1;
        #1;
        check("stallrst_in_ready", in_ready, 1);

        // Reset mid-flight: two sets accepted, third offered during reset.
        a = 16'h1111; b = 16'h2222; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 16'h3333; b = 16'h4444;
        @(posedge clk); #1;
        a = 16'h5555; b = 16'h6666;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_s", s, 0);
        @(posedge clk); #1;
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        check("midrst_in_ready", in_ready, 1);
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) stale++;
        end
        check("midrst_stale", stale, 0);
        run_one(tbl[0], "post_rst");

        run_stream(60, 1'b1, "rnd");

        // STAGES sweep at WIDTH=8: output after edge e belongs to edge e-S+1.
        for (int e = 1; e <= 150; e++) begin
            v8 = ($urandom % 4 != 0); a8 = 8'($urandom); b8 = 8'($urandom);
            c8 = 1'($urandom); sb8 = 1'($urandom);
            hv[e] = v8; ha[e] = a8; hb[e] = b8; hc[e] = c8; hs[e] = sb8;
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++) begin
                st  = (d == 0) ? 1 : ((d == 1) ? 2 : 8);
                src = e - st + 1;
                ev  = (src >= 1) ? hv[src] : 1'b0;
                check($sformatf("sw%0d_valid", st), ov8[d], ev);
                if (ev) begin
                    r = model(8, {8'h00, ha[src]}, {8'h00, hb[src]}, hc[src], hs[src]);
                    check($sformatf("sw%0d_s", st), s8[d], r[7:0]);
                    check($sformatf("sw%0d_cout", st), co8[d], r[16]);
                    check($sformatf("sw%0d_ovf", st), of8[d], r[17]);
                end
            end
        end
        v8 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
